// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus port among NUM_REQ requesters; grant held until ready && last.
// Grant is one cycle after request; losers hold valid and wait. CBUS_ARB_FIXED_PRIORITY_EN makes index 0 highest priority.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       oresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       iresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             txn_done;

  assign txn_done = iresp.ready && iresp.last;

`ifndef CBUS_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;

  // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
  function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CBUS_ARB_FIXED_PRIORITY_EN
      if (!pick_vld && ireqs[i].valid) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
`else
      if (!pick_vld && ireqs[rr_slot(rr_ptr, i)].valid) begin
        pick_vld = 1'b1;
        pick_idx = rr_slot(rr_ptr, i);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      grant_idx <= '0;
`ifndef CBUS_ARB_FIXED_PRIORITY_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (txn_done) begin
`ifndef CBUS_ARB_FIXED_PRIORITY_EN
            rr_ptr <= next_ptr;
`endif
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pass-through is gated by state, so an async reset clears the outputs at once.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) oresps[i] = '0;
    if (state == S_BUSY) begin
      oreq              = ireqs[grant_idx];
      oresps[grant_idx] = iresp;
    end
  end

  // The owner must keep valid high until it has seen ready && last.
  granted_valid_held_a: assert property (@(posedge clk) disable iff (reset)
                                         (state == S_BUSY) |-> oreq.valid);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a 2-requester and a 3-requester instance, with grant and response scoreboards.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_req_t  ireqs2 [2];
  cbus_resp_t oresps2[2];
  cbus_req_t  oreq2;
  cbus_resp_t iresp2;
  logic       busy2;
  logic [0:0] gidx2;

  cbus_req_t  ireqs3 [3];
  cbus_resp_t oresps3[3];
  cbus_req_t  oreq3;
  cbus_resp_t iresp3;
  logic       busy3;
  logic [1:0] gidx3;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_grant[$];
  logic [31:0] exp_data[$];

  cbus_arbiter #(.NUM_REQ(2)) u_dut2 (
    .clk(clk), .reset(reset), .ireqs(ireqs2), .oresps(oresps2),
    .oreq(oreq2), .iresp(iresp2), .busy(busy2), .grant_idx(gidx2)
  );

  cbus_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .reset(reset), .ireqs(ireqs3), .oresps(oresps3),
    .oreq(oreq3), .iresp(iresp3), .busy(busy3), .grant_idx(gidx3)
  );

  function automatic logic [31:0] req_addr(input int i);
    return 32'h8000_0000 + 32'(i) * 32'h10;
  endfunction

  function automatic cbus_req_t mk_req(input int i, input logic v);
    cbus_req_t r;
    r = '0;
    if (v) begin
      r.valid  = 1'b1;
      r.size   = 3'd2;
      r.addr   = req_addr(i);
      r.strobe = 4'hf;
      r.data   = 32'hC0DE_0000 + 32'(i);
    end
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  task automatic set_reqs(input logic [1:0] m2, input logic [2:0] m3);
    for (int i = 0; i < 2; i++) ireqs2[i] = mk_req(i, m2[i]);
    for (int i = 0; i < 3; i++) ireqs3[i] = mk_req(i, m3[i]);
  endtask

  // Leaves the bench just after a clock edge with reset released and the given requests valid.
  task automatic do_reset(input logic [1:0] m2, input logic [2:0] m3);
    reset = 1'b1;
    set_reqs(2'b00, 3'b000);
    iresp2 = '0;
    iresp3 = '0;
    exp_grant.delete();
    exp_data.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    set_reqs(m2, m3);
  endtask

  // Responds to each grant after one cycle with `beats` beats, scoring grants, beats and the idle bubble.
  task automatic serve(input bit use3, input int n_txn, input int beats);
    int          done, beat, cur, g, n, cyc;
    bit          active, bubble_pending, rdy_drv, last_drv;
    logic        b;
    logic [31:0] dat, want;
    cbus_resp_t  obs, oth;
    cbus_req_t   oq;
    n = use3 ? 3 : 2;
    done = 0; beat = 0; cur = 0; active = 0; bubble_pending = 0;
    for (cyc = 0; cyc < 200 && (done < n_txn || bubble_pending); cyc++) begin
      @(posedge clk); #1;
      rdy_drv = 1'b0; last_drv = 1'b0; dat = '0;
      if (active) begin
        beat++;
        rdy_drv  = 1'b1;
        last_drv = (beat == beats);
        dat      = 32'hB000_0000 + 32'(done * 16 + beat);
        exp_data.push_back(dat);
      end
      if (use3) iresp3 = mk_resp(rdy_drv, last_drv, dat);
      else      iresp2 = mk_resp(rdy_drv, last_drv, dat);
      @(negedge clk);
      b  = use3 ? busy3 : busy2;
      g  = use3 ? int'(gidx3) : int'(gidx2);
      oq = use3 ? oreq3 : oreq2;
      if (bubble_pending) begin
        n_checks++;
        if (b !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_bubble txn%0d: busy=%b, want 0", done, b);
        end
        bubble_pending = 0;
      end else if (b === 1'b1 && !active) begin
        n_checks++;
        if (exp_grant.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got grant %0d, none expected", g);
        end else begin
          cur = exp_grant.pop_front();
          if (g != cur) begin
            n_fail++;
            $display("FAIL grant_order txn%0d: got %0d, want %0d", done, g, cur);
          end
        end
        n_checks++;
        if (oq.valid !== 1'b1 || oq.addr !== req_addr(cur)) begin
          n_fail++;
          $display("FAIL oreq_fwd txn%0d: valid=%b addr=%h, want 1 %h", done, oq.valid, oq.addr, req_addr(cur));
        end
        active = 1; beat = 0;
      end else if (active && rdy_drv) begin
        obs  = use3 ? oresps3[cur] : oresps2[cur];
        want = exp_data.pop_front();
        n_checks++;
        if (obs.data !== want || obs.ready !== 1'b1 || obs.last !== last_drv) begin
          n_fail++;
          $display("FAIL beat_fwd txn%0d beat%0d: got r=%b l=%b d=%h, want r=1 l=%b d=%h",
                   done, beat, obs.ready, obs.last, obs.data, last_drv, want);
        end
        n_checks++;
        if (b !== 1'b1 || g != cur) begin
          n_fail++;
          $display("FAIL grant_held txn%0d beat%0d: busy=%b idx=%0d, want 1 %0d", done, beat, b, g, cur);
        end
        for (int k = 0; k < n; k++) begin
          if (k != cur) begin
            oth = use3 ? oresps3[k] : oresps2[k];
            n_checks++;
            if (oth !== '0) begin
              n_fail++;
              $display("FAIL resp_isolation txn%0d: oresps[%0d]=%h, want 0", done, k, oth);
            end
          end
        end
        if (last_drv) begin
          active = 0;
          done++;
          bubble_pending = 1;
        end
      end
    end
    n_checks++;
    if (done < n_txn || bubble_pending) begin
      n_fail++;
      $display("FAIL serve_timeout: completed %0d, want %0d", done, n_txn);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_reqs(2'b11, 3'b111);
    iresp2 = mk_resp(1'b1, 1'b1, 32'hFFFF_FFFF);
    iresp3 = mk_resp(1'b1, 1'b1, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    n_checks++;
    if (busy2 !== 1'b0 || gidx2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs2: busy=%b idx=%0d, want 0 0", busy2, gidx2);
    end
    n_checks++;
    if (oreq2 !== '0) begin
      n_fail++; $display("FAIL reset_oreq2: got %h, want 0", oreq2);
    end
    n_checks++;
    if (oresps2[0] !== '0 || oresps2[1] !== '0) begin
      n_fail++; $display("FAIL reset_oresps2: got %h %h, want 0", oresps2[0], oresps2[1]);
    end
    n_checks++;
    if (busy3 !== 1'b0 || gidx3 !== 2'd0 || oreq3 !== '0) begin
      n_fail++; $display("FAIL reset_dut3: busy=%b idx=%0d oreq=%h, want 0", busy3, gidx3, oreq3);
    end
  endtask

  task automatic test_single();
    do_reset(2'b10, 3'b000);
    exp_grant.push_back(1);
    @(negedge clk);
    n_checks++;
    if (oreq2.valid !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL single_cycle0: valid=%b busy=%b, want 0 0", oreq2.valid, busy2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (oreq2.valid !== 1'b1 || oreq2.addr !== 32'h8000_0010 || busy2 !== 1'b1 || int'(gidx2) != exp_grant.pop_front()) begin
      n_fail++; $display("FAIL single_cycle1: valid=%b addr=%h busy=%b idx=%0d, want 1 80000010 1 1",
                         oreq2.valid, oreq2.addr, busy2, gidx2);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    iresp2 = mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    exp_data.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    n_checks++;
    if (oresps2[1] !== mk_resp(1'b1, 1'b1, exp_data.pop_front())) begin
      n_fail++; $display("FAIL single_resp: oresps[1]=%h, want ready/last data deadbeef", oresps2[1]);
    end
    n_checks++;
    if (oresps2[0] !== '0) begin
      n_fail++; $display("FAIL single_other: oresps[0]=%h, want 0", oresps2[0]);
    end
    @(posedge clk); #1;
    iresp2 = '0;
    set_reqs(2'b00, 3'b000);
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b0 || oreq2.valid !== 1'b0) begin
      n_fail++; $display("FAIL single_cycle4: busy=%b valid=%b, want 0 0", busy2, oreq2.valid);
    end
  endtask

  task automatic test_contention();
    do_reset(2'b11, 3'b000);
`ifdef CBUS_ARB_FIXED_PRIORITY_EN
    exp_grant = '{0, 0, 0, 0};
`else
    exp_grant = '{0, 1, 0, 1};
`endif
    serve(1'b0, 4, 1);
  endtask

  task automatic test_burst();
    do_reset(2'b10, 3'b000);
    exp_grant.push_back(1);
    serve(1'b0, 1, 4);
  endtask

  task automatic test_late_arrival();
    do_reset(2'b01, 3'b000);
    exp_grant.push_back(0);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b1 || int'(gidx2) != exp_grant.pop_front()) begin
      n_fail++; $display("FAIL late_grant0: busy=%b idx=%0d, want 1 0", busy2, gidx2);
    end
    @(posedge clk); #1;
    ireqs2[1] = mk_req(1, 1'b1);
    iresp2 = mk_resp(1'b0, 1'b0, 32'h1234_5678);
    @(negedge clk);
    n_checks++;
    if (oresps2[1] !== '0 || oresps2[0].data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL late_wait: oresps[1]=%h oresps[0].data=%h, want 0 12345678", oresps2[1], oresps2[0].data);
    end
    @(posedge clk); #1;
    iresp2 = mk_resp(1'b1, 1'b1, 32'hA5A5_0001);
    exp_grant.push_back(1);
    @(negedge clk);
    n_checks++;
    if (oresps2[1] !== '0 || oresps2[0] !== mk_resp(1'b1, 1'b1, 32'hA5A5_0001)) begin
      n_fail++; $display("FAIL late_done0: oresps[1]=%h oresps[0]=%h, want 0 and the final beat", oresps2[1], oresps2[0]);
    end
    @(posedge clk); #1;
    iresp2 = '0;
    ireqs2[0] = mk_req(0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b0 || oresps2[1] !== '0) begin
      n_fail++; $display("FAIL late_bubble: busy=%b oresps[1]=%h, want 0 0", busy2, oresps2[1]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b1 || int'(gidx2) != exp_grant.pop_front() || oreq2.addr !== req_addr(1)) begin
      n_fail++; $display("FAIL late_grant1: busy=%b idx=%0d addr=%h, want 1 1 %h", busy2, gidx2, oreq2.addr, req_addr(1));
    end
    @(posedge clk); #1;
    iresp2 = mk_resp(1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    iresp2 = '0;
    set_reqs(2'b00, 3'b000);
  endtask

  task automatic test_reset_mid();
    do_reset(2'b01, 3'b000);
    exp_grant.push_back(0);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b1 || int'(gidx2) != exp_grant.pop_front()) begin
      n_fail++; $display("FAIL rmid_grant0: busy=%b idx=%0d, want 1 0", busy2, gidx2);
    end
    @(posedge clk); #1;
    iresp2 = mk_resp(1'b0, 1'b0, 32'h5555_AAAA);
    ireqs2[1] = mk_req(1, 1'b1);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (oreq2 !== '0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: oreq=%h busy=%b, want 0 0", oreq2, busy2);
    end
    n_checks++;
    if (oresps2[0] !== '0 || oresps2[1] !== '0) begin
      n_fail++; $display("FAIL rmid_oresps: got %h %h, want 0 0", oresps2[0], oresps2[1]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ireqs2[0] = mk_req(0, 1'b0);
    iresp2 = '0;
    exp_grant.push_back(1);
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_idle: busy=%b, want 0", busy2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b1 || int'(gidx2) != exp_grant.pop_front()) begin
      n_fail++; $display("FAIL rmid_grant1: busy=%b idx=%0d, want 1 1", busy2, gidx2);
    end
    @(posedge clk); #1;
    iresp2 = mk_resp(1'b1, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    n_checks++;
    if (oresps2[1].data !== 32'h0BAD_F00D || oresps2[0] !== '0) begin
      n_fail++; $display("FAIL rmid_resp1: oresps[1].data=%h oresps[0]=%h, want 0badf00d 0", oresps2[1].data, oresps2[0]);
    end
    @(posedge clk); #1;
    iresp2 = '0;
    set_reqs(2'b00, 3'b000);
  endtask

  task automatic test_wrap3();
    do_reset(2'b00, 3'b111);
`ifdef CBUS_ARB_FIXED_PRIORITY_EN
    exp_grant = '{0, 0, 0, 0};
`else
    exp_grant = '{0, 1, 2, 0};
`endif
    serve(1'b1, 4, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_late_arrival();
    test_reset_mid();
    test_wrap3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
